fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Program sequencer for the 8-bit accumulator-style core.
- Owns the program counter and drives the combinational instruction ROM address.
- Issues each fetched instruction to the datapath and resolves `jmp` / `beq0` through an 8-entry label table, including forward references.
- Starts a selected program on request and reports completion or fault.

Parameters:
- ADDR_W, 8, PC / ROM address width
- INST_W, 8, instruction width
- NUM_LABELS, 8, label table entries (3-bit label id)
- PROG0_BASE, 8'h00, entry address when prog_sel_i=0
- PROG1_BASE, 8'h40, entry address when prog_sel_i=1

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  pulse; begin execution (honoured only in IDLE/DONE/FAULT)
- prog_sel_i  in  1  entry select, sampled with start_i
- instruction_i  in  8  ROM data for pc_o (combinational, same cycle)
- cond_zero_i  in  1  datapath zero flag from last pushv, sampled on beq0 cycle
- pc_o  out  8  ROM address
- inst_o  out  8  instruction handed to datapath
- inst_valid_o  out  1  datapath executes inst_o this cycle
- busy_o  out  1  high in RUN/SCAN
- done_o  out  1  high in DONE
- fault_o  out  1  high in FAULT

Behaviour:
- Decoded fields:
  - MARK = 1111_0nnn: label marker.
  - JMP = 0111_0nnn.
  - BEQ0 = 0110_0nnn.
  - HALT = 1110_0000.
  - ILLEGAL = 1111_1111.
  - All else is passed to the datapath.
- Reset: state=IDLE, pc_o=0, inst_valid_o=0, busy_o=0, done_o=0, fault_o=0, all label valid bits cleared. inst_o = instruction_i at all times (no register).
- IDLE/DONE/FAULT + start_i:
  - pc <= prog_sel_i ? PROG1_BASE : PROG0_BASE.
  - Clear all label valid bits; state <= RUN.
  - A start_i while busy is ignored.
- RUN (one instruction per cycle; inst_valid_o=1 except on MARK, HALT, ILLEGAL, and every instruction that transitions to SCAN):
  - MARK n: table[n] <= pc+1, valid[n] <= 1, pc <= pc+1, not issued. A re-definition overwrites the entry.
  - JMP n, valid[n]: pc <= table[n], issued.
  - BEQ0 n, valid[n]: pc <= cond_zero_i ? table[n] : pc+1, issued.
  - JMP n or BEQ0 n (with cond_zero_i=1), !valid[n]: latch target id n; pc <= pc+1; state <= SCAN. Not issued (inst_valid_o=0).
  - BEQ0 not taken: pc+1, issued regardless of label validity.
  - HALT: state <= DONE; pc holds; not issued.
  - ILLEGAL: state <= FAULT; not issued.
  - Other: issued, pc <= pc+1.
- SCAN (forward-label search, inst_valid_o=0):
  - Every MARK m encountered records table[m]=pc+1 and valid[m].
  - If m == target: pc <= pc+1, state <= RUN.
  - Otherwise pc <= pc+1.
  - Reaching ILLEGAL, or pc == 8'hFF without a match, goes to FAULT.
- Branch latency:
  - Taken branch to a known label: 1 cycle, so the target issues the next cycle.
  - Forward branch: 1 cycle plus one cycle per skipped word.
- PC arithmetic: 8-bit wrap in RUN; a wrap from 8'hFF to 8'h00 in RUN also goes to FAULT.
- DONE/FAULT: sticky until start_i or reset.
- Mid-operation reset: reset_n_i low immediately returns to reset values, asynchronously.

Optional Feature:
- Macro: FETCH_SEQ_PERF_EN.
- Defined:
  - Add output issued_cnt_o[15:0], counting inst_valid_o cycles.
  - Add output stall_cnt_o[15:0], counting SCAN cycles plus unissued RUN cycles.
  - Both clear on start_i and reset; both saturate at 16'hFFFF.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package fetch_seq_pkg holds:
  - state enum {IDLE, RUN, SCAN, DONE, FAULT};
  - opcode match constants (MARK_HI=5'b11110, JMP_HI=5'b01110, BEQ0_HI=5'b01100, HALT=8'hE0, ILLEGAL=8'hFF);
  - PROG0_BASE / PROG1_BASE defaults.
- One sub-module, label_table: 8×8 storage plus valid bits, with a write port, a read port, and clear.

Test Plan:
1. Reset held, then released with no start -> pc_o=0, busy_o=0, done_o=0, fault_o=0, inst_valid_o=0.
2. start_i, prog_sel_i=1, ROM model with MARK0 at 8'h4B, JMP0 at 8'h51 -> 8'h4C issued one cycle after the MARK; after the JMP, pc_o=8'h4C next cycle.
3. BEQ0 4 at 8'h18 with label 4 undefined, cond_zero_i=1 -> SCAN through pc 8'h19..8'h39; MARK4 at 8'h39; RUN resumes at 8'h3A; no inst_valid_o during SCAN. Repeat with cond_zero_i=0 -> 8'h19 issued next cycle.
4. HALT at 8'h3F -> done_o=1, pc_o stays 8'h3F; a second start_i with prog_sel_i=0 -> pc_o=8'h00, done_o=0.
5. Forward JMP to a never-defined label -> SCAN hits 8'hFF in ROM default -> fault_o=1. Also, start_i while busy_o=1 -> ignored.
6. Assert reset_n_i during SCAN -> all outputs return to reset values in the same cycle; after start_i, the label table is empty, so a previously known label triggers SCAN again.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Shared types and opcode constants for the fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StScan,
    StDone,
    StFault
  } state_e;

  typedef enum logic [2:0] {
    OpOther,
    OpMark,
    OpJmp,
    OpBeq0,
    OpHalt,
    OpIllegal
  } op_e;

  localparam logic [4:0] MARK_HI = 5'b11110;
  localparam logic [4:0] JMP_HI  = 5'b01110;
  localparam logic [4:0] BEQ0_HI = 5'b01100;
  localparam logic [7:0] HALT    = 8'hE0;
  localparam logic [7:0] ILLEGAL = 8'hFF;

  localparam logic [7:0] PROG0_BASE_DEF = 8'h00;
  localparam logic [7:0] PROG1_BASE_DEF = 8'h40;

  // Classify one instruction word; everything unrecognised belongs to the datapath.
  function automatic op_e decode_op(input logic [7:0] inst);
    op_e op;
    op = OpOther;
    if (inst == ILLEGAL) begin
      op = OpIllegal;
    end else if (inst == HALT) begin
      op = OpHalt;
    end else if (inst[7:3] == MARK_HI) begin
      op = OpMark;
    end else if (inst[7:3] == JMP_HI) begin
      op = OpJmp;
    end else if (inst[7:3] == BEQ0_HI) begin
      op = OpBeq0;
    end
    return op;
  endfunction

endpackage

// File: rtl/fetch_sequencer_label_table.sv
// Label table: one target address per label id plus a valid bit, cleared as a whole.
module label_table #(
  parameter int unsigned NUM_LABELS = 8,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          clr_i,
  input  logic                          we_i,
  input  logic [$clog2(NUM_LABELS)-1:0] waddr_i,
  input  logic [DATA_W-1:0]             wdata_i,
  input  logic [$clog2(NUM_LABELS)-1:0] raddr_i,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          rvalid_o
);

  logic [DATA_W-1:0]     entry_q [NUM_LABELS];
  logic [NUM_LABELS-1:0] valid_q;

  // Valid bits: reset and clear win over a write.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= '0;
    end else if (clr_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[waddr_i] <= 1'b1;
    end
  end

  // Entry storage needs no reset; it is only read behind a valid bit.
  always_ff @(posedge clk_i) begin
    if (we_i && !clr_i) begin
      entry_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o  = entry_q[raddr_i];
  assign rvalid_o = valid_q[raddr_i];

endmodule

// File: rtl/fetch_sequencer.sv
// Program sequencer: owns the PC, issues instructions, resolves jmp/beq0 via labels.
// Optional performance counters are built when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       INST_W     = 8,
  parameter int unsigned       NUM_LABELS = 8,
  parameter logic [ADDR_W-1:0] PROG0_BASE = ADDR_W'(PROG0_BASE_DEF),
  parameter logic [ADDR_W-1:0] PROG1_BASE = ADDR_W'(PROG1_BASE_DEF)
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic              prog_sel_i,
  input  logic [INST_W-1:0] instruction_i,
  input  logic              cond_zero_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              fault_o
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [15:0]       issued_cnt_o,
  output logic [15:0]       stall_cnt_o
`endif
);

  localparam int unsigned LblW = $clog2(NUM_LABELS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [LblW-1:0]   target_q, target_d, lbl;
  logic              busy_q, done_q, fault_q;
  logic              pc_wrap, advance, issue;
  logic              lt_clr, lt_we, lt_valid;
  logic [ADDR_W-1:0] lt_rdata;
  op_e               op;

  assign op      = decode_op(instruction_i);
  assign lbl     = instruction_i[LblW-1:0];
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign pc_wrap = (pc_q == '1);

  label_table #(
    .NUM_LABELS (NUM_LABELS),
    .DATA_W     (ADDR_W)
  ) u_label_table (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (lt_clr),
    .we_i      (lt_we),
    .waddr_i   (lbl),
    .wdata_i   (pc_inc),
    .raddr_i   (lbl),
    .rdata_o   (lt_rdata),
    .rvalid_o  (lt_valid)
  );

  // Next state, next PC, label writes and issue decision for the current word.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    lt_clr   = 1'b0;
    lt_we    = 1'b0;
    issue    = 1'b0;
    advance  = 1'b0;
    unique case (state_q)
      StIdle, StDone, StFault: begin
        if (start_i) begin
          pc_d    = prog_sel_i ? PROG1_BASE : PROG0_BASE;
          lt_clr  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        unique case (op)
          OpIllegal: state_d = StFault;
          OpHalt:    state_d = StDone;
          OpMark: begin
            lt_we   = 1'b1;
            advance = 1'b1;
          end
          OpJmp, OpBeq0: begin
            if (op == OpBeq0 && !cond_zero_i) begin
              issue   = 1'b1;
              advance = 1'b1;
            end else if (lt_valid) begin
              issue = 1'b1;
              pc_d  = lt_rdata;
            end else begin
              // Unknown label: search forward for its marker without issuing.
              target_d = lbl;
              state_d  = StScan;
              advance  = 1'b1;
            end
          end
          default: begin
            issue   = 1'b1;
            advance = 1'b1;
          end
        endcase
        if (advance) begin
          if (pc_wrap) begin
            state_d = StFault;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      StScan: begin
        if (op == OpIllegal) begin
          state_d = StFault;
        end else begin
          // Every marker passed on the way is recorded, not just the target.
          lt_we = (op == OpMark);
          if (op == OpMark && lbl == target_q) begin
            pc_d    = pc_inc;
            state_d = StRun;
          end else if (pc_wrap) begin
            state_d = StFault;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, PC and registered status flags.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      target_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      busy_q   <= (state_d == StRun) || (state_d == StScan);
      done_q   <= (state_d == StDone);
      fault_q  <= (state_d == StFault);
    end
  end

  assign pc_o         = pc_q;
  assign inst_o       = instruction_i;
  assign inst_valid_o = issue;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign fault_o      = fault_q;

`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] issued_cnt_q, stall_cnt_q;
  logic        start_acc, stall;

  assign start_acc = start_i && (state_q inside {StIdle, StDone, StFault});
  assign stall     = (state_q == StScan) || ((state_q == StRun) && !issue);

  // Saturating issue/stall counters, cleared by an accepted start.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      issued_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else if (start_acc) begin
      issued_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (issue && issued_cnt_q != 16'hFFFF) begin
        issued_cnt_q <= issued_cnt_q + 16'd1;
      end
      if (stall && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign issued_cnt_o = issued_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized ROM programs
// compared every cycle against a behavioural model of the sequencing rules.
module tb_fetch_sequencer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       prog_sel;
  logic       cond_zero;
  logic [7:0] instruction;
  logic [7:0] pc;
  logic [7:0] inst;
  logic       inst_valid;
  logic       busy;
  logic       done;
  logic       fault;

  logic [7:0] rom [256];
  assign instruction = rom[pc];

  fetch_sequencer dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .start_i       (start),
    .prog_sel_i    (prog_sel),
    .instruction_i (instruction),
    .cond_zero_i   (cond_zero),
    .pc_o          (pc),
    .inst_o        (inst),
    .inst_valid_o  (inst_valid),
    .busy_o        (busy),
    .done_o        (done),
    .fault_o       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_SCAN = 2, M_DONE = 3, M_FAULT = 4;
  localparam int K_OTHER = 0, K_MARK = 1, K_JMP = 2, K_BEQ = 3, K_HALT = 4, K_ILL = 5;

  int m_mode;
  int m_pc;
  int m_tgt;
  int lab [8];  // -1 = label not known

  function automatic int kind_of(input logic [7:0] i);
    if (i == 8'hFF) return K_ILL;
    if (i == 8'hE0) return K_HALT;
    if (i[7:3] == 5'b11110) return K_MARK;
    if (i[7:3] == 5'b01110) return K_JMP;
    if (i[7:3] == 5'b01100) return K_BEQ;
    return K_OTHER;
  endfunction

  task automatic m_reset();
    m_mode = M_IDLE;
    m_pc   = 0;
    m_tgt  = 0;
    for (int i = 0; i < 8; i++) lab[i] = -1;
  endtask

  function automatic bit m_issue();
    logic [7:0] ins;
    int k;
    int id;
    if (m_mode != M_RUN) return 1'b0;
    ins = rom[m_pc];
    k   = kind_of(ins);
    id  = int'(ins[2:0]);
    case (k)
      K_MARK, K_HALT, K_ILL: return 1'b0;
      K_JMP:                 return lab[id] >= 0;
      K_BEQ:                 return !cond_zero || lab[id] >= 0;
      default:               return 1'b1;
    endcase
  endfunction

  task automatic m_step();
    logic [7:0] ins;
    int k;
    int id;
    int nxt;
    ins = rom[m_pc];
    k   = kind_of(ins);
    id  = int'(ins[2:0]);
    nxt = -1;
    case (m_mode)
      M_IDLE, M_DONE, M_FAULT: begin
        if (start) begin
          m_pc = prog_sel ? 64 : 0;
          for (int i = 0; i < 8; i++) lab[i] = -1;
          m_mode = M_RUN;
        end
      end
      M_RUN: begin
        case (k)
          K_ILL:  m_mode = M_FAULT;
          K_HALT: m_mode = M_DONE;
          K_MARK: begin
            lab[id] = (m_pc + 1) % 256;
            nxt = m_pc + 1;
          end
          K_JMP, K_BEQ: begin
            if (k == K_BEQ && !cond_zero) nxt = m_pc + 1;
            else if (lab[id] >= 0) m_pc = lab[id];
            else begin
              m_tgt  = id;
              m_mode = M_SCAN;
              nxt    = m_pc + 1;
            end
          end
          default: nxt = m_pc + 1;
        endcase
        if (nxt > 255) m_mode = M_FAULT;
        else if (nxt >= 0) m_pc = nxt;
      end
      M_SCAN: begin
        if (k == K_ILL) m_mode = M_FAULT;
        else if (k == K_MARK && id == m_tgt) begin
          lab[id] = (m_pc + 1) % 256;
          m_pc    = (m_pc + 1) % 256;
          m_mode  = M_RUN;
        end else begin
          if (k == K_MARK) lab[id] = (m_pc + 1) % 256;
          if (m_pc == 255) m_mode = M_FAULT;
          else m_pc = m_pc + 1;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_reset();
    else m_step();
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [7:0] e_pc;
    logic [7:0] e_inst;
    bit e_v;
    bit e_b;
    bit e_d;
    bit e_f;
    if (cmp_en) begin
      e_pc   = 8'(m_pc);
      e_inst = rom[m_pc];
      e_v    = m_issue();
      e_b    = (m_mode == M_RUN) || (m_mode == M_SCAN);
      e_d    = (m_mode == M_DONE);
      e_f    = (m_mode == M_FAULT);
      checks++;
      if (pc !== e_pc || inst !== e_inst || inst_valid !== e_v || busy !== e_b ||
          done !== e_d || fault !== e_f) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got pc=%h inst=%h v=%b b=%b d=%b f=%b, expected pc=%h inst=%h v=%b b=%b d=%b f=%b",
                 $time, pc, inst, inst_valid, busy, done, fault,
                 e_pc, e_inst, e_v, e_b, e_d, e_f);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [7:0] target, input int budget, input string name);
    int n;
    n = 0;
    while (pc !== target && n < budget) begin
      tick();
      n++;
    end
    chk(name, {24'd0, pc}, {24'd0, target});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start(input logic sel);
    start    = 1'b1;
    prog_sel = sel;
    tick();
    start = 1'b0;
  endtask

  task automatic rom_fill_plain();
    for (int a = 0; a < 256; a++) rom[a] = 8'h01;
    rom[255] = 8'hFF;
  endtask

  function automatic logic [7:0] rand_inst();
    int r;
    logic [7:0] w;
    r = int'($urandom_range(0, 99));
    w = 8'($urandom);
    if (r < 12) return {5'b11110, w[2:0]};
    if (r < 20) return {5'b01110, w[2:0]};
    if (r < 28) return {5'b01100, w[2:0]};
    if (r < 30) return 8'hE0;
    if (r < 31) return 8'hFF;
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int v;
    for (int a = 0; a < 256; a++) rom[a] = 8'hFF;
    reset_n   = 1'b0;
    start     = 1'b0;
    prog_sel  = 1'b0;
    cond_zero = 1'b0;
    m_reset();

    // 1: reset values with no start
    tick();
    tick();
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    repeat (3) tick();
    chk("rst_pc", {24'd0, pc}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);

    // 2: prog 1, known-label backward jump; start while busy is ignored
    rom_fill_plain();
    rom[8'h4B] = 8'hF0;
    rom[8'h51] = 8'h70;
    pulse_start(1'b1);
    chk("t2_entry", {24'd0, pc}, 32'h40);
    wait_pc(8'h4B, 20, "t2_reach_mark");
    chk("t2_mark_not_issued", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("t2_after_mark_pc", {24'd0, pc}, 32'h4C);
    chk("t2_after_mark_valid", {31'd0, inst_valid}, 32'd1);
    wait_pc(8'h51, 20, "t2_reach_jmp");
    chk("t2_jmp_issued", {31'd0, inst_valid}, 32'd1);
    tick();
    chk("t2_jmp_target", {24'd0, pc}, 32'h4C);
    pulse_start(1'b0);
    chk("t2_busy_start_ignored", {24'd0, pc}, 32'h4D);

    // 3: forward beq0 with cond_zero=1 scans to MARK4
    do_reset();
    rom_fill_plain();
    rom[8'h18] = 8'h64;
    rom[8'h39] = 8'hF4;
    rom[8'h3F] = 8'hE0;
    cond_zero  = 1'b1;
    pulse_start(1'b0);
    wait_pc(8'h18, 40, "t3_reach_beq");
    chk("t3_beq_not_issued", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("t3_scan_start", {24'd0, pc}, 32'h19);
    n = 0;
    v = 0;
    while (pc !== 8'h3A && n < 64) begin
      v += int'(inst_valid);
      tick();
      n++;
    end
    chk("t3_scan_no_issue", v, 0);
    chk("t3_scan_cycles", n, 33);
    chk("t3_resume_valid", {31'd0, inst_valid}, 32'd1);

    // 4: halt, sticky done, restart with prog 0
    wait_pc(8'h3F, 20, "t4_reach_halt");
    chk("t4_halt_not_issued", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("t4_done", {31'd0, done}, 32'd1);
    tick();
    chk("t4_done_sticky", {31'd0, done}, 32'd1);
    chk("t4_pc_hold", {24'd0, pc}, 32'h3F);
    pulse_start(1'b0);
    chk("t4_restart_pc", {24'd0, pc}, 32'h00);
    chk("t4_restart_done", {31'd0, done}, 32'd0);
    cond_zero = 1'b0;
    wait_pc(8'h18, 40, "t4_reach_beq");
    chk("t4_beq_nt_issued", {31'd0, inst_valid}, 32'd1);
    tick();
    chk("t4_beq_nt_pc", {24'd0, pc}, 32'h19);

    // 5: forward jmp to undefined label faults at 8'hFF; start during scan ignored
    do_reset();
    rom_fill_plain();
    rom[8'h42] = 8'h77;
    pulse_start(1'b1);
    wait_pc(8'h43, 10, "t5_scan_entry");
    pulse_start(1'b0);
    chk("t5_scan_start_ignored", {24'd0, pc}, 32'h44);
    n = 0;
    while (fault !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("t5_fault", {31'd0, fault}, 32'd1);
    chk("t5_fault_not_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t5_fault_sticky", {31'd0, fault}, 32'd1);

    // 6: async reset during scan, then a formerly known label scans again
    do_reset();
    rom_fill_plain();
    rom[8'h40] = 8'hF3;
    rom[8'h42] = 8'h74;
    rom[8'h50] = 8'hF4;
    rom[8'h51] = 8'h75;
    rom[8'h60] = 8'hF5;
    rom[8'h61] = 8'h73;
    pulse_start(1'b1);
    wait_pc(8'h51, 40, "t6_reach_51");
    wait_pc(8'h58, 40, "t6_in_scan");
    chk("t6_scan_busy", {31'd0, busy}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_async_pc", {24'd0, pc}, 32'h0);
    chk("t6_async_busy", {31'd0, busy}, 32'd0);
    chk("t6_async_valid", {31'd0, inst_valid}, 32'd0);
    chk("t6_async_flags", {30'd0, done, fault}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    pulse_start(1'b1);
    wait_pc(8'h42, 10, "t6_reach_jmp4");
    chk("t6_jmp4_unknown", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("t6_rescan_pc", {24'd0, pc}, 32'h43);
    chk("t6_rescan_busy", {31'd0, busy}, 32'd1);

    // Randomized programs checked by the per-cycle model comparison
    for (int p = 0; p < 30; p++) begin
      do_reset();
      for (int a = 0; a < 255; a++) rom[a] = rand_inst();
      rom[255] = 8'hFF;
      pulse_start(1'($urandom_range(0, 1)));
      for (int c = 0; c < 400; c++) begin
        cond_zero = 1'($urandom_range(0, 1));
        start     = ($urandom_range(0, 15) == 0);
        prog_sel  = 1'($urandom_range(0, 1));
        reset_n   = ($urandom_range(0, 299) != 0);
        tick();
      end
      start   = 1'b0;
      reset_n = 1'b1;
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
